timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//   Memory-mapped programmable down-counter on the CPU's peripheral bus, behind the address bridge.
//   Two instances: timer 0 at 0x7F00-0x7F0B, timer 1 at 0x7F10-0x7F1B.
//   The bridge decodes the window and drives per-device write enable. This block decodes addr[3:2] only.
//   irq feeds one HWInt bit (timer 0 -> HWInt[10], timer 1 -> HWInt[11]).
// PARAMETERS
//   COUNT_W  32  width of PRESET/COUNT (1..32); reads zero-extend to 32 bits
// PORTS
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high
//   addr   in   32  byte address from bridge; only [3:2] used
//   we     in   1   write strobe for this instance (already window-decoded)
//   din    in   32  write data
//   dout   out  32  read data, combinational from addr[3:2]
//   irq    out  1   interrupt request, registered-state driven
// BEHAVIOUR
//   Register map (addr[3:2]):
//     0 CTRL   R/W; [0]=EN, [2:1]=MODE, [3]=IM; [31:4] read 0, write ignored
//     1 PRESET R/W; reload value
//     2 COUNT  RO; writes ignored
//     3 reserved; reads 0, writes ignored
//   Reset (sync): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so irq=0.
//   irq = irq_flag & CTRL.IM. dout has no latency (same-cycle read).
//   Writes commit at the clock edge where we=1.
//   FSM (2-bit state) -- IDLE, LOAD, CNT, INT:
//     IDLE: EN=1 -> LOAD; else hold. COUNT holds its value.
//     LOAD: COUNT<=PRESET; EN=1 -> CNT, EN=0 -> IDLE.
//     CNT:  EN=0 -> IDLE, COUNT frozen.
//           COUNT>1 -> COUNT<=COUNT-1, stay.
//           COUNT<=1 -> COUNT<=0, ->INT, irq_flag<=1.
//     INT:  MODE==1 -> next edge irq_flag<=0, ->LOAD (auto-reload; irq high for exactly 1 cycle).
//           MODE!=1 (0,2,3 all act as one-shot) -> next edge EN<=0, ->IDLE;
//           irq_flag stays set until software writes CTRL.
//   Latency: with PRESET=P>=1, the edge after the EN write moves IDLE->LOAD.
//     irq_flag sets P+2 edges after that. PRESET=0 behaves like P=1.
//   Write effects:
//     - Any CTRL write clears irq_flag (acknowledge).
//     - PRESET writes take effect only at the next LOAD; the running COUNT is unaffected.
//   Collisions:
//     - CPU CTRL write in the same cycle as the INT hardware EN-clear: the CPU value wins.
//     - CTRL write in the same cycle as CNT->INT: irq_flag ends up set (the hardware event wins over the ack).
//   Mode change while counting takes effect at the next INT decision.
//   Reset mid-count: everything returns to its reset value on that edge; no irq glitch.
//   Arithmetic: COUNT is unsigned COUNT_W bits and never wraps below 0.
//     PRESET write truncates din to COUNT_W bits.
// TESTING
//   1 Reset, then read all four offsets -> dout=0 for each; irq=0.
//   2 PRESET=3, CTRL=0x9 (EN, mode0, IM), written at edge E0:
//     E1 LOAD, E2 COUNT=3, E3=2, E4=1, E5 COUNT=0 and irq=1;
//     E6 EN=0 and IDLE, irq still 1; CTRL write -> irq=0 after that edge.
//   3 PRESET=2, CTRL=0xB (mode1): irq pulses for one cycle every 4 cycles (INT, LOAD, CNT x2);
//     COUNT reads 2,1,0 repeatedly.
//   4 CTRL=0x1 (IM=0), mode0, PRESET=1: irq stays 0 but the internal flag sets;
//     a later write of CTRL=0x8 leaves irq=0 (ack cleared the flag).
//   5 Start a count with PRESET=100; write PRESET=5 mid-count -> the count continues from the old value.
//     Clearing EN freezes COUNT. Reset mid-count -> all registers 0 on the next edge.
//   6 Write COUNT and offset 3 with 0xFFFFFFFF -> no change; reading offset 3 -> 0.
//     CTRL write of 0xFFFFFFFF -> reads back 0xF.

Source files
------------

// File: rtl/timer_counter_if.sv
// Peripheral bus port of the timer: window-decoded write strobe,
// byte address, write data, same-cycle read data and interrupt.
interface timer_counter_if;
   logic [31:0] addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   modport master (
      output addr, we, din,
      input  dout, irq
   );

   modport slave (
      input  addr, we, din,
      output dout, irq
   );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with one-shot and
// auto-reload modes; decodes addr[3:2] for CTRL/PRESET/COUNT.
module timer_counter #(
   parameter int COUNT_W = 32
) (
   input logic         clk,
   input logic         reset,
   timer_counter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   state_t             state, state_nx;
   logic [3:0]         ctrl, ctrl_nx;
   logic [COUNT_W-1:0] preset, preset_nx;
   logic [COUNT_W-1:0] count, count_nx;
   logic               irq_flag, irq_flag_nx;

   logic       en;
   logic [1:0] mode;
   logic       im;
   logic       wr_ctrl;
   logic       wr_preset;
   logic       last;
   logic       unused_bits;

   assign en        = ctrl[0];
   assign mode      = ctrl[2:1];
   assign im        = ctrl[3];
   assign wr_ctrl   = bus.we && (bus.addr[3:2] == 2'd0);
   assign wr_preset = bus.we && (bus.addr[3:2] == 2'd1);
   assign last      = (count <= COUNT_W'(1));

   assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.din};

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         irq_flag <= 1'b0;
      end else begin
         state    <= state_nx;
         ctrl     <= ctrl_nx;
         preset   <= preset_nx;
         count    <= count_nx;
         irq_flag <= irq_flag_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      ctrl_nx     = ctrl;
      preset_nx   = preset;
      count_nx    = count;
      irq_flag_nx = irq_flag;

      unique case (state)
         IDLE: begin
            if (en) state_nx = LOAD;
         end
         LOAD: begin
            count_nx = preset;
            state_nx = en ? CNT : IDLE;
         end
         CNT: begin
            if (!en) begin
               state_nx = IDLE;
            end else if (last) begin
               count_nx = '0;
               state_nx = INT;
            end else begin
               count_nx = count - COUNT_W'(1);
            end
         end
         INT: begin
            if (mode == 2'd1) begin
               state_nx = LOAD;
            end else begin
               state_nx   = IDLE;
               ctrl_nx[0] = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (wr_preset) preset_nx = bus.din[COUNT_W-1:0];

      // CPU write overrides the hardware EN-clear and acks the flag
      if (wr_ctrl) begin
         ctrl_nx     = bus.din[3:0];
         irq_flag_nx = 1'b0;
      end

      if (state == INT && mode == 2'd1) irq_flag_nx = 1'b0;

      // expiry beats a simultaneous ack
      if (state == CNT && en && last) irq_flag_nx = 1'b1;
   end

   always_comb begin
      bus.dout = '0;
      unique case (bus.addr[3:2])
         2'd0: bus.dout = {28'd0, ctrl};
         2'd1: bus.dout = 32'(preset);
         2'd2: bus.dout = 32'(count);
         2'd3: bus.dout = '0;
         default: bus.dout = '0;
      endcase
      bus.irq = irq_flag & im;
   end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed bus cycles push
// expected dout/irq; a negedge monitor pops and compares.
module tb_timer_counter;

   localparam logic [31:0] A_CTRL = 32'h7F00;
   localparam logic [31:0] A_PRE  = 32'h7F04;
   localparam logic [31:0] A_CNT  = 32'h7F08;
   localparam logic [31:0] A_RSV  = 32'h7F0C;

   typedef struct {
      string       name;
      logic [31:0] dout;
      logic        irq;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   bit   rd_req = 1'b0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   timer_counter_if ifc ();

   timer_counter #(.COUNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rd_req) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: read with no expected entry");
         end else begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (ifc.dout !== e.dout) begin
               errors++;
               $display("FAIL %s dout: got %h want %h",
                        e.name, ifc.dout, e.dout);
            end
            checks++;
            if (ifc.irq !== e.irq) begin
               errors++;
               $display("FAIL %s irq: got %b want %b",
                        e.name, ifc.irq, e.irq);
            end
         end
      end
   end

   task automatic cyc(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input bit c,
                      input logic [31:0] ed, input logic ei,
                      input string nm);
      ifc.addr = a;
      ifc.din  = d;
      ifc.we   = w;
      rd_req   = c;
      if (c) sb.push_back('{name: nm, dout: ed, irq: ei});
      @(posedge clk);
      #1;
      ifc.we = 1'b0;
      rd_req = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cyc(1'b1, a, d, 1'b0, 32'd0, 1'b0, "");
   endtask

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] ed, input logic ei);
      cyc(1'b0, a, 32'd0, 1'b1, ed, ei, nm);
   endtask

   task automatic idle();
      cyc(1'b0, A_RSV, 32'd0, 1'b0, 32'd0, 1'b0, "");
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      ifc.we = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      ifc.addr = '0;
      ifc.din  = '0;
      ifc.we   = 1'b0;
      do_reset();

      // reset state
      chk("rst_ctrl", A_CTRL, 32'd0, 1'b0);
      chk("rst_pre",  A_PRE,  32'd0, 1'b0);
      chk("rst_cnt",  A_CNT,  32'd0, 1'b0);
      chk("rst_rsv",  A_RSV,  32'd0, 1'b0);

      // one-shot, P=3
      wr(A_PRE, 32'd3);
      wr(A_CTRL, 32'h9);
      chk("os_e0", A_CNT, 32'd0, 1'b0);
      chk("os_e1", A_CNT, 32'd0, 1'b0);
      chk("os_e2", A_CNT, 32'd3, 1'b0);
      chk("os_e3", A_CNT, 32'd2, 1'b0);
      chk("os_e4", A_CNT, 32'd1, 1'b0);
      chk("os_e5", A_CNT, 32'd0, 1'b1);
      chk("os_e6", A_CTRL, 32'h8, 1'b1);
      wr(A_CTRL, 32'h8);
      chk("os_ack", A_CTRL, 32'h8, 1'b0);

      // auto-reload, P=2
      do_reset();
      wr(A_PRE, 32'd2);
      wr(A_CTRL, 32'hB);
      chk("ar_idle", A_CNT, 32'd0, 1'b0);
      chk("ar_load", A_CNT, 32'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         chk("ar_c2",   A_CNT, 32'd2, 1'b0);
         chk("ar_c1",   A_CNT, 32'd1, 1'b0);
         chk("ar_int",  A_CNT, 32'd0, 1'b1);
         chk("ar_ld",   A_CNT, 32'd0, 1'b0);
      end

      // masked interrupt, ack clears hidden flag
      do_reset();
      wr(A_PRE, 32'd1);
      wr(A_CTRL, 32'h1);
      chk("im_e0", A_CNT, 32'd0, 1'b0);
      chk("im_e1", A_CNT, 32'd0, 1'b0);
      chk("im_e2", A_CNT, 32'd1, 1'b0);
      chk("im_e3", A_CNT, 32'd0, 1'b0);
      chk("im_ctrl", A_CTRL, 32'h0, 1'b0);
      wr(A_CTRL, 32'h8);
      chk("im_ack", A_CTRL, 32'h8, 1'b0);

      // PRESET rewrite mid-count, freeze, reset mid-count
      do_reset();
      wr(A_PRE, 32'd100);
      wr(A_CTRL, 32'h1);
      idle();
      idle();
      idle();
      wr(A_PRE, 32'd5);
      chk("mc_98", A_CNT, 32'd98, 1'b0);
      chk("mc_pre", A_PRE, 32'd5, 1'b0);
      wr(A_CTRL, 32'h0);
      chk("fz_a", A_CNT, 32'd95, 1'b0);
      chk("fz_b", A_CNT, 32'd95, 1'b0);
      chk("fz_c", A_CNT, 32'd95, 1'b0);
      wr(A_CTRL, 32'h9);
      idle();
      idle();
      idle();
      chk("rl_4", A_CNT, 32'd4, 1'b0);
      do_reset();
      chk("mr_ctrl", A_CTRL, 32'd0, 1'b0);
      chk("mr_pre",  A_PRE,  32'd0, 1'b0);
      chk("mr_cnt",  A_CNT,  32'd0, 1'b0);

      // read-only and reserved offsets, CTRL width
      wr(A_PRE, 32'd7);
      wr(A_CNT, 32'hFFFF_FFFF);
      wr(A_RSV, 32'hFFFF_FFFF);
      chk("ro_cnt", A_CNT, 32'd0, 1'b0);
      chk("ro_rsv", A_RSV, 32'd0, 1'b0);
      chk("ro_pre", A_PRE, 32'd7, 1'b0);
      wr(A_CTRL, 32'hFFFF_FFFF);
      chk("ctrl_w", A_CTRL, 32'hF, 1'b0);

      // collisions: expiry vs ack, CPU vs EN-clear
      do_reset();
      wr(A_PRE, 32'd1);
      wr(A_CTRL, 32'h9);
      chk("co_e0", A_CNT, 32'd0, 1'b0);
      chk("co_e1", A_CNT, 32'd0, 1'b0);
      cyc(1'b1, A_CTRL, 32'h9, 1'b1, 32'h9, 1'b0, "co_cnt");
      cyc(1'b1, A_CTRL, 32'hD, 1'b1, 32'h9, 1'b1, "co_hw");
      chk("co_cpu", A_CTRL, 32'hD, 1'b0);

      idle();
      idle();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d left want 0", sb.size());
      end
      checks++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
